// File: rtl/load_store_unit_if.sv
// Core/memory bundle for the load/store unit.
// Request, response and word-memory port share one interface.
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_store;
   logic [2:0]            req_funct3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;

   logic                  resp_valid;
   logic [31:0]           resp_rdata;
   logic                  resp_misaligned;
   logic                  resp_illegal;

   logic [ADDR_WIDTH-1:0] mem_address;
   logic [31:0]           mem_write_data;
   logic                  mem_write_enable;
   logic                  mem_read_enable;
   logic [31:0]           mem_read_data;

   // Core plus data memory: issues requests, returns read words.
   modport master (
      output req_valid,
      output req_store,
      output req_funct3,
      output req_addr,
      output req_wdata,
      output mem_read_data,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_misaligned,
      input  resp_illegal,
      input  mem_address,
      input  mem_write_data,
      input  mem_write_enable,
      input  mem_read_enable
   );

   // The load/store unit itself.
   modport slave (
      input  req_valid,
      input  req_store,
      input  req_funct3,
      input  req_addr,
      input  req_wdata,
      input  mem_read_data,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_misaligned,
      output resp_illegal,
      output mem_address,
      output mem_write_data,
      output mem_write_enable,
      output mem_read_enable
   );

endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: byte/half/word access over a word-wide memory.
// Sub-word stores use read-modify-write; errors skip memory entirely.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [1:0]            state_q, state_d;
   logic                  store_q, store_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  illegal_q, illegal_d;
   logic                  misal_q, misal_d;

   logic in_idle;
   logic in_rd;
   logic in_wr;
   logic in_resp;
   logic accept;
   logic req_illegal;
   logic req_misal;
   logic req_err;
   logic req_sw;
   logic [1:0] off;

   // Pick the addressed lane of a read word and extend it.
   function automatic logic [31:0] load_align(
      input logic [31:0] word,
      input logic [2:0]  f3,
      input logic [1:0]  lane
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      unique case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_BU:   r = {24'd0, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_HU:   r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Splice store data into the old word; full-word stores replace it.
   function automatic logic [31:0] store_merge(
      input logic [31:0] word,
      input logic [2:0]  f3,
      input logic [1:0]  lane,
      input logic [31:0] wd
   );
      logic [31:0] r;
      r = word;
      unique case (f3)
         F3_B:    r[{lane, 3'b000} +: 8] = wd[7:0];
         F3_H:    r[{lane[1], 4'b0000} +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   // Reset masks every state so outputs are quiet while it is held.
   assign in_idle = (state_q == S_IDLE) && !rst;
   assign in_rd   = (state_q == S_RD) && !rst;
   assign in_wr   = (state_q == S_WR) && !rst;
   assign in_resp = (state_q == S_RESP) && !rst;

   assign accept = bus.req_valid && in_idle;
   assign off    = addr_q[1:0];

   // Classify the incoming request; illegal hides misaligned.
   always_comb begin
      req_illegal = 1'b0;
      req_misal   = 1'b0;
      if (bus.req_store) begin
         req_illegal = !(bus.req_funct3 inside {F3_B, F3_H, F3_W});
      end else begin
         req_illegal = bus.req_funct3 inside {3'b011, 3'b110, 3'b111};
      end
      unique case (bus.req_funct3)
         F3_H, F3_HU: req_misal = bus.req_addr[0];
         F3_W:        req_misal = |bus.req_addr[1:0];
         default:     req_misal = 1'b0;
      endcase
      req_misal = req_misal && !req_illegal;
   end

   assign req_err = req_illegal || req_misal;
   assign req_sw  = bus.req_store && (bus.req_funct3 == F3_W);

   // Next state and request latch, loaded only on the accept edge.
   always_comb begin
      state_d   = state_q;
      store_d   = store_q;
      funct3_d  = funct3_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      illegal_d = illegal_q;
      misal_d   = misal_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               store_d   = bus.req_store;
               funct3_d  = bus.req_funct3;
               addr_d    = bus.req_addr;
               wdata_d   = bus.req_wdata;
               illegal_d = req_illegal;
               misal_d   = req_misal;
               unique case (1'b1)
                  req_err:                      state_d = S_RESP;
                  !req_err && !bus.req_store:   state_d = S_RD;
                  !req_err && req_sw:           state_d = S_WR;
                  !req_err && bus.req_store
                           && !req_sw:          state_d = S_RD;
                  default:                      state_d = S_IDLE;
               endcase
            end
         end
         S_RD:    state_d = store_q ? S_WR : S_RESP;
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Register update; reset drops any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         store_q   <= 1'b0;
         funct3_q  <= 3'd0;
         addr_q    <= '0;
         wdata_q   <= 32'd0;
         illegal_q <= 1'b0;
         misal_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         store_q   <= store_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         illegal_q <= illegal_d;
         misal_q   <= misal_d;
      end
   end

   assign bus.req_ready = in_idle;

   assign bus.mem_read_enable  = in_rd;
   assign bus.mem_write_enable = in_wr;

   assign bus.mem_address = (in_rd || in_wr) ?
                            {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;

   assign bus.mem_write_data = in_wr ?
      store_merge(bus.mem_read_data, funct3_q, off, wdata_q) : 32'd0;

   assign bus.resp_valid      = in_resp;
   assign bus.resp_illegal    = in_resp && illegal_q;
   assign bus.resp_misaligned = in_resp && misal_q;

   assign bus.resp_rdata =
      (in_resp && !store_q && !illegal_q && !misal_q) ?
      load_align(bus.mem_read_data, funct3_q, off) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, RMW/reset/back-to-back
// sequences and random requests against a behavioural model.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_load = 1'b1;

   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;

   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];

   function automatic logic [31:0] init_word(input int i);
      return (i == 1) ? 32'hDEADBEEF :
                        32'h5A3C96E1 ^ (32'(i) * 32'h01010101);
   endfunction

   // Word memory: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else begin
         if (bus.mem_read_enable)
            bus.mem_read_data <= mem[bus.mem_address[5:2]];
         if (bus.mem_write_enable)
            mem[bus.mem_address[5:2]] <= bus.mem_write_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Reference: access rules computed with plain arithmetic.
   task automatic model(
      input bit st, input bit [2:0] f3,
      input bit [31:0] a, input bit [31:0] wd,
      output int lat, output bit [31:0] rd,
      output bit mis, output bit ill,
      output int nrd, output int nwr,
      output bit [31:0] waddr, output bit [31:0] wdat
   );
      int size, off, idx;
      longint word, mask, v, span;
      ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off = int'(a % 4);
      idx = int'((a / 4) % 16);
      mis = !ill && ((a % size) != 0);
      lat = 1; rd = 0; nrd = 0; nwr = 0; waddr = 0; wdat = 0;
      if (ill || mis) return;
      word = longint'(ref_mem[idx]);
      span = longint'(1) << (8 * size);
      if (!st) begin
         lat = 2;
         nrd = 1;
         v = (word >> (8 * off)) % span;
         if (!f3[2] && size < 4 && v >= span / 2) v = v - span;
         rd = v[31:0];
      end else begin
         lat = (size == 4) ? 2 : 3;
         nrd = (size == 4) ? 0 : 1;
         nwr = 1;
         mask = (span - 1) << (8 * off);
         word = (word & ~mask) | ((longint'(wd) << (8 * off)) & mask);
         ref_mem[idx] = word[31:0];
         waddr = a & ~32'h3;
         wdat = word[31:0];
      end
   endtask

   int          o_lat, o_nrd, o_nwr;
   logic [31:0] o_rd, o_waddr, o_wdata;
   logic        o_mis, o_ill, o_bad;

   // Issue one request, scramble inputs after accept, observe.
   task automatic txn(input bit st, input bit [2:0] f3,
                      input bit [31:0] a, input bit [31:0] wd);
      o_lat = 0; o_nrd = 0; o_nwr = 0;
      o_rd = 0; o_waddr = 0; o_wdata = 0;
      o_mis = 0; o_ill = 0; o_bad = 0;
      @(negedge clk);
      if (!bus.req_ready) o_bad = 1;
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.mem_read_enable) o_nrd++;
         if (bus.mem_write_enable) begin
            o_nwr++;
            o_waddr = bus.mem_address;
            o_wdata = bus.mem_write_data;
         end
         if (bus.mem_read_enable && bus.mem_write_enable) o_bad = 1;
         if (bus.req_ready) o_bad = 1;
         if (bus.resp_valid) begin
            o_lat = c;
            o_rd  = bus.resp_rdata;
            o_mis = bus.resp_misaligned;
            o_ill = bus.resp_illegal;
            break;
         end
         if (bus.resp_rdata != 0 || bus.resp_misaligned ||
             bus.resp_illegal) o_bad = 1;
      end
   endtask

   typedef struct {
      bit        st;
      bit [2:0]  f3;
      bit [31:0] addr;
      bit [31:0] wd;
      int        lat;
      bit [31:0] rd;
      bit        mis;
      bit        ill;
      int        nrd;
      int        nwr;
      bit [31:0] waddr;
      bit [31:0] wdat;
   } vec_t;

   vec_t tbl [18];

   int          m_lat, m_nrd, m_nwr;
   bit [31:0]   m_rd, m_waddr, m_wdat;
   bit          m_mis, m_ill;
   int          w1, w2, r1, r2, rdy;
   logic [31:0] w1a, w1d, w2a, w2d;
   logic        bad;

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

      tbl[0]  = '{0, 3'b000, 32'h7, 32'h0, 2, 32'hFFFFFFDE, 0, 0, 1, 0, 0, 0};
      tbl[1]  = '{0, 3'b100, 32'h7, 32'h0, 2, 32'h000000DE, 0, 0, 1, 0, 0, 0};
      tbl[2]  = '{0, 3'b001, 32'h6, 32'h0, 2, 32'hFFFFDEAD, 0, 0, 1, 0, 0, 0};
      tbl[3]  = '{0, 3'b101, 32'h4, 32'h0, 2, 32'h0000BEEF, 0, 0, 1, 0, 0, 0};
      tbl[4]  = '{0, 3'b010, 32'h4, 32'h0, 2, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0};
      tbl[5]  = '{1, 3'b001, 32'h3, 32'h1234, 1, 32'h0, 1, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 3'b011, 32'h4, 32'h0, 1, 32'h0, 0, 1, 0, 0, 0, 0};
      tbl[7]  = '{1, 3'b000, 32'h5, 32'h12, 3, 32'h0, 0, 0, 1, 1,
                  32'h4, 32'hDEAD12EF};
      tbl[8]  = '{0, 3'b010, 32'h4, 32'h0, 2, 32'hDEAD12EF, 0, 0, 1, 0, 0, 0};
      tbl[9]  = '{1, 3'b100, 32'h4, 32'h77, 1, 32'h0, 0, 1, 0, 0, 0, 0};
      tbl[10] = '{0, 3'b010, 32'h6, 32'h0, 1, 32'h0, 1, 0, 0, 0, 0, 0};
      tbl[11] = '{1, 3'b011, 32'h1, 32'h0, 1, 32'h0, 0, 1, 0, 0, 0, 0};
      tbl[12] = '{1, 3'b010, 32'h8, 32'hCAFEF00D, 2, 32'h0, 0, 0, 0, 1,
                  32'h8, 32'hCAFEF00D};
      tbl[13] = '{0, 3'b001, 32'h9, 32'h0, 1, 32'h0, 1, 0, 0, 0, 0, 0};
      tbl[14] = '{1, 3'b001, 32'h6, 32'hAAAA5555, 3, 32'h0, 0, 0, 1, 1,
                  32'h4, 32'h555512EF};
      tbl[15] = '{0, 3'b000, 32'h8, 32'h0, 2, 32'h0000000D, 0, 0, 1, 0, 0, 0};
      tbl[16] = '{0, 3'b001, 32'hA, 32'h0, 2, 32'hFFFFCAFE, 0, 0, 1, 0, 0, 0};
      tbl[17] = '{0, 3'b101, 32'hA, 32'h0, 2, 32'h0000CAFE, 0, 0, 1, 0, 0, 0};

      // Reset held: everything quiet.
      repeat (2) @(negedge clk);
      mem_load = 1'b0;
      check("rst_resp_valid", 32'(bus.resp_valid), 0);
      check("rst_strobes", {30'd0, bus.mem_read_enable,
                            bus.mem_write_enable}, 0);
      check("rst_mem_address", bus.mem_address, 0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_req_ready", 32'(bus.req_ready), 1);
      check("idle_outputs", {bus.mem_write_data[29:0],
                             bus.resp_misaligned, bus.resp_illegal}, 0);
      check("idle_mem_write_data", bus.mem_write_data, 0);

      // Reset in the middle of an SH read-modify-write.
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b1;
      bus.req_funct3 = 3'b001;
      bus.req_addr   = 32'h4;
      bus.req_wdata  = 32'h5555;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("rmw_rd_strobe", 32'(bus.mem_read_enable), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rmw_abort_ready", 32'(bus.req_ready), 1);
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (bus.mem_write_enable || bus.resp_valid ||
             bus.mem_read_enable) bad = 1'b1;
         @(negedge clk);
      end
      check("rmw_abort_quiet", 32'(bad), 0);
      check("rmw_abort_word", mem[1], 32'hDEADBEEF);

      // Directed vectors.
      for (int i = 0; i < 18; i++) begin
         txn(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd);
         model(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, m_lat,
               m_rd, m_mis, m_ill, m_nrd, m_nwr, m_waddr, m_wdat);
         check($sformatf("v%0d_latency", i), 32'(o_lat), 32'(tbl[i].lat));
         check($sformatf("v%0d_rdata", i), o_rd, tbl[i].rd);
         check($sformatf("v%0d_misaligned", i), 32'(o_mis), 32'(tbl[i].mis));
         check($sformatf("v%0d_illegal", i), 32'(o_ill), 32'(tbl[i].ill));
         check($sformatf("v%0d_reads", i), 32'(o_nrd), 32'(tbl[i].nrd));
         check($sformatf("v%0d_writes", i), 32'(o_nwr), 32'(tbl[i].nwr));
         check($sformatf("v%0d_waddr", i), o_waddr, tbl[i].waddr);
         check($sformatf("v%0d_wdata", i), o_wdata, tbl[i].wdat);
         check($sformatf("v%0d_protocol", i), 32'(o_bad), 0);
      end

      // Two SW requests with req_valid held high throughout.
      w1 = 0; w2 = 0; r1 = 0; r2 = 0; rdy = 0;
      w1a = 0; w1d = 0; w2a = 0; w2d = 0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h11112222;
      @(posedge clk);
      #1;
      bus.req_addr  = 32'h14;
      bus.req_wdata = 32'h33334444;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.mem_write_enable) begin
            if (w1 == 0) begin
               w1 = c; w1a = bus.mem_address; w1d = bus.mem_write_data;
            end else if (w2 == 0) begin
               w2 = c; w2a = bus.mem_address; w2d = bus.mem_write_data;
            end
         end
         if (bus.resp_valid) begin
            if (r1 == 0) r1 = c;
            else if (r2 == 0) r2 = c;
         end
         if (bus.req_ready && rdy == 0) rdy = c;
         if (c == 4) bus.req_valid = 1'b0;
      end
      model(1, 3'b010, 32'h10, 32'h11112222, m_lat, m_rd, m_mis, m_ill,
            m_nrd, m_nwr, m_waddr, m_wdat);
      model(1, 3'b010, 32'h14, 32'h33334444, m_lat, m_rd, m_mis, m_ill,
            m_nrd, m_nwr, m_waddr, m_wdat);
      check("b2b_write1_cycle", 32'(w1), 1);
      check("b2b_write1_addr", w1a, 32'h10);
      check("b2b_write1_data", w1d, 32'h11112222);
      check("b2b_resp1_cycle", 32'(r1), 2);
      check("b2b_ready_cycle", 32'(rdy), 3);
      check("b2b_write2_cycle", 32'(w2), 4);
      check("b2b_write2_addr", w2a, 32'h14);
      check("b2b_write2_data", w2d, 32'h33334444);
      check("b2b_resp2_cycle", 32'(r2), 5);
      check("b2b_word1", mem[4], 32'h11112222);
      check("b2b_word2", mem[5], 32'h33334444);

      // Random requests against the model.
      for (int i = 0; i < 80; i++) begin
         automatic bit        st = 1'($urandom);
         automatic bit [2:0]  f3 = 3'($urandom_range(0, 7));
         automatic bit [31:0] a  = 32'($urandom_range(0, 63));
         automatic bit [31:0] wd = $urandom;
         txn(st, f3, a, wd);
         model(st, f3, a, wd, m_lat, m_rd, m_mis, m_ill, m_nrd, m_nwr,
               m_waddr, m_wdat);
         check($sformatf("r%0d_latency", i), 32'(o_lat), 32'(m_lat));
         check($sformatf("r%0d_rdata", i), o_rd, m_rd);
         check($sformatf("r%0d_flags", i), {30'd0, o_mis, o_ill},
               {30'd0, m_mis, m_ill});
         check($sformatf("r%0d_strobes", i), 32'(o_nrd * 4 + o_nwr),
               32'(m_nrd * 4 + m_nwr));
         check($sformatf("r%0d_write", i), o_wdata ^ o_waddr,
               m_wdat ^ m_waddr);
         check($sformatf("r%0d_protocol", i), 32'(o_bad), 0);
         check($sformatf("r%0d_mem_word", i), mem[a[5:2]], ref_mem[a[5:2]]);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
